// File: rtl/apb_rr_master_if.sv
// -----------------------------------------------------------------------------
// apb_rr_master_if
//   Bundles the requester-side handshake and the APB bus of apb_rr_master.
//
//   Requester side (flattened vectors, requester i at [i*W +: W]):
//     req_valid, req_write, req_addr, req_wdata   -> into the master
//     req_ack, rsp_rdata, rsp_err, grant_id       <- from the master
//   APB side:
//     PSEL, PENABLE, PADDR, PWRITE, PWDATA        <- from the master
//     PREADY, PRDATA, PSLVERR                     -> into the master
//
//   modport master : view taken by apb_rr_master
//   modport slave  : view taken by whatever surrounds it (requesters + APB slave)
// -----------------------------------------------------------------------------
interface apb_rr_master_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   localparam int ID_W = $clog2(NUM_REQ);

   // requester handshake
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic [ID_W-1:0]           grant_id;

   // APB bus
   logic                      PSEL;
   logic                      PENABLE;
   logic [ADDR_W-1:0]         PADDR;
   logic                      PWRITE;
   logic [DATA_W-1:0]         PWDATA;
   logic                      PREADY;
   logic [DATA_W-1:0]         PRDATA;
   logic                      PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ack, rsp_rdata, rsp_err, grant_id,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ack, rsp_rdata, rsp_err, grant_id,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_rr_master.sv
// -----------------------------------------------------------------------------
// apb_rr_master
//   Round-robin APB master: NUM_REQ local requesters share one APB slave port.
//   The FSM picks a winner in IDLE, latches its command, runs SETUP/ACCESS and
//   returns read data / error with a one-cycle one-hot acknowledge. A slave that
//   keeps PREADY low for TIMEOUT ACCESS cycles is cut off with an error ack.
//
//   Ports:
//     PCLK    clock, rising edge
//     PRESET  asynchronous reset, active-high
//     bus     apb_rr_master_if.master (requester handshake + APB bus)
//
//   All outputs are registered. Reset leaves the RR pointer at NUM_REQ-1 so
//   requester 0 has first priority.
// -----------------------------------------------------------------------------
module apb_rr_master #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic           PCLK,
   input  logic           PRESET,
   apb_rr_master_if.master bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t               state_reg;
   logic [ID_W-1:0]      ptr_reg;
   logic [CNT_W-1:0]     wait_cnt_reg;

   logic                 psel_reg;
   logic                 penable_reg;
   logic [ADDR_W-1:0]    paddr_reg;
   logic                 pwrite_reg;
   logic [DATA_W-1:0]    pwdata_reg;
   logic [NUM_REQ-1:0]   ack_reg;
   logic [DATA_W-1:0]    rdata_reg;
   logic                 err_reg;
   logic [ID_W-1:0]      grant_reg;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   // The requester being acknowledged this cycle still has req_valid high (it
   // only drops it after seeing the ack), so it must not be granted again.
   logic [NUM_REQ-1:0]   eligible;
   assign eligible = bus.req_valid & ~ack_reg;

   // Scan position gi looks at requester (ptr+1+gi) mod NUM_REQ, so position 0
   // is the requester right after the last winner.
   logic [ID_W-1:0]      scan_idx [NUM_REQ];
   logic [NUM_REQ-1:0]   scan_hit;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
      assign scan_idx[gi] = ID_W'((int'(ptr_reg) + gi + 1) % NUM_REQ);
      assign scan_hit[gi] = eligible[scan_idx[gi]];
   end

   logic                 found;
   logic [ID_W-1:0]      winner;

   // Walk from the lowest priority upward so the earliest scan position wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (scan_hit[k]) begin
            found  = 1'b1;
            winner = scan_idx[k];
         end
      end
   end

   // Winner's command fields, selected out of the flattened request vectors.
   logic [ADDR_W-1:0]    win_addr;
   logic [DATA_W-1:0]    win_wdata;
   logic                 win_write;

   assign win_addr  = bus.req_addr[int'(winner) * ADDR_W +: ADDR_W];
   assign win_wdata = bus.req_wdata[int'(winner) * DATA_W +: DATA_W];
   assign win_write = bus.req_write[winner];

   // ---------------------------------------------------------------------------
   // Transfer FSM (all outputs registered here)
   // ---------------------------------------------------------------------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_reg    <= IDLE;
         ptr_reg      <= ID_W'(NUM_REQ - 1);
         wait_cnt_reg <= '0;
         psel_reg     <= 1'b0;
         penable_reg  <= 1'b0;
         paddr_reg    <= '0;
         pwrite_reg   <= 1'b0;
         pwdata_reg   <= '0;
         ack_reg      <= '0;
         rdata_reg    <= '0;
         err_reg      <= 1'b0;
         grant_reg    <= '0;
      end else begin
         // ack is a single-cycle pulse; every other output holds unless updated
         ack_reg <= '0;

         case (state_reg)
            IDLE: begin
               if (found) begin
                  paddr_reg  <= win_addr;
                  pwrite_reg <= win_write;
                  pwdata_reg <= win_write ? win_wdata : '0;
                  grant_reg  <= winner;
                  ptr_reg    <= winner;
                  psel_reg   <= 1'b1;
                  state_reg  <= SETUP;
               end
            end

            SETUP: begin
               penable_reg  <= 1'b1;
               wait_cnt_reg <= '0;
               state_reg    <= ACCESS;
            end

            ACCESS: begin
               if (bus.PREADY) begin
                  psel_reg    <= 1'b0;
                  penable_reg <= 1'b0;
                  ack_reg     <= NUM_REQ'(1) << grant_reg;
                  rdata_reg   <= pwrite_reg ? '0 : bus.PRDATA;
                  err_reg     <= bus.PSLVERR;
                  state_reg   <= IDLE;
               end else if (wait_cnt_reg == CNT_LAST) begin
                  // slave stalled for TIMEOUT cycles: abandon with an error ack
                  psel_reg    <= 1'b0;
                  penable_reg <= 1'b0;
                  ack_reg     <= NUM_REQ'(1) << grant_reg;
                  rdata_reg   <= '0;
                  err_reg     <= 1'b1;
                  state_reg   <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end

            default: begin
               psel_reg    <= 1'b0;
               penable_reg <= 1'b0;
               state_reg   <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------------
   assign bus.PSEL      = psel_reg;
   assign bus.PENABLE   = penable_reg;
   assign bus.PADDR     = paddr_reg;
   assign bus.PWRITE    = pwrite_reg;
   assign bus.PWDATA    = pwdata_reg;
   assign bus.req_ack   = ack_reg;
   assign bus.rsp_rdata = rdata_reg;
   assign bus.rsp_err   = err_reg;
   assign bus.grant_id  = grant_reg;

endmodule

// File: tb/tb_apb_rr_master.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_master
//   Scenario tasks drive requests, push the expected response of each request
//   to a scoreboard queue and pop/compare it when the ack pulse appears. A small
//   APB slave model (memory, programmable wait states, stall, error address)
//   answers the bus. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_apb_rr_master;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_rr_master_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_rr_master #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK  (clk),
      .PRESET(rst),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // ---------------- APB slave model ----------------
   logic [31:0] mem [0:255];
   int          slv_wait = 0;
   bit          slv_hang = 1'b0;
   bit          err_en   = 1'b0;
   logic [31:0] err_addr = 32'hC;
   int          wcnt;

   always_comb begin
      bus.PREADY  = bus.PSEL && bus.PENABLE && !slv_hang && (wcnt >= slv_wait);
      bus.PRDATA  = slv_hang ? 32'hDEAD_BEEF : mem[bus.PADDR[9:2]];
      bus.PSLVERR = err_en && (bus.PADDR == err_addr);
   end

   always @(posedge clk) begin
      if (rst) begin
         wcnt <= 0;
      end else begin
         if (bus.PSEL && bus.PENABLE && !bus.PREADY) wcnt <= wcnt + 1;
         else                                        wcnt <= 0;
         if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
            mem[bus.PADDR[9:2]] <= bus.PWDATA;
      end
   end

   // ---------------- stimulus helpers (no comparisons) ----------------
   task automatic set_req(input int i, input bit v, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
      bus.req_valid[i]               = v;
      bus.req_write[i]               = w;
      bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
      bus.req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic wait_ack(input int budget, output int cycles, output bit ok);
      cycles = budget;
      ok     = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (bus.req_ack != '0) begin
            cycles = c;
            ok     = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.PSEL !== 1'b0)     $display("FAIL reset_psel: got %b want 0", bus.PSEL); else pass_cnt++;
      total_cnt++; if (bus.PENABLE !== 1'b0)  $display("FAIL reset_penable: got %b want 0", bus.PENABLE); else pass_cnt++;
      total_cnt++; if (bus.PADDR !== '0)      $display("FAIL reset_paddr: got %h want 0", bus.PADDR); else pass_cnt++;
      total_cnt++; if (bus.PWRITE !== 1'b0)   $display("FAIL reset_pwrite: got %b want 0", bus.PWRITE); else pass_cnt++;
      total_cnt++; if (bus.PWDATA !== '0)     $display("FAIL reset_pwdata: got %h want 0", bus.PWDATA); else pass_cnt++;
      total_cnt++; if (bus.req_ack !== '0)    $display("FAIL reset_ack: got %b want 0", bus.req_ack); else pass_cnt++;
      total_cnt++; if (bus.rsp_rdata !== '0)  $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); else pass_cnt++;
      total_cnt++; if (bus.rsp_err !== 1'b0)  $display("FAIL reset_err: got %b want 0", bus.rsp_err); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== '0)   $display("FAIL reset_grant: got %0d want 0", bus.grant_id); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      exp_t e;
      int   cyc;
      bit   ok;
      slv_wait = 0;
      set_req(0, 1'b1, 1'b1, 32'h4, 32'hABCD);
      sb.push_back('{id: 0, rdata: 32'h0, err: 1'b0});
      @(negedge clk);   // SETUP
      total_cnt++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) $display("FAIL wr_setup: got psel=%b pen=%b want 1/0", bus.PSEL, bus.PENABLE); else pass_cnt++;
      total_cnt++; if (bus.PADDR !== 32'h4 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'hABCD)
         $display("FAIL wr_cmd: got a=%h w=%b d=%h want 4/1/abcd", bus.PADDR, bus.PWRITE, bus.PWDATA); else pass_cnt++;
      @(negedge clk);   // ACCESS
      total_cnt++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 || bus.PADDR !== 32'h4)
         $display("FAIL wr_access: got psel=%b pen=%b a=%h want 1/1/4", bus.PSEL, bus.PENABLE, bus.PADDR); else pass_cnt++;
      wait_ack(8, cyc, ok);
      total_cnt++; if (!ok || cyc != 1) $display("FAIL wr_latency: got ok=%b extra=%0d want 1/1", ok, cyc); else pass_cnt++;
      e = sb.pop_front();
      $display("ack id=%0d ack=%b rdata=%h err=%b", e.id, bus.req_ack, bus.rsp_rdata, bus.rsp_err);
      total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL wr_ack: got %b want onehot %0d", bus.req_ack, e.id); else pass_cnt++;
      total_cnt++; if (bus.rsp_err !== e.err) $display("FAIL wr_err: got %b want %b", bus.rsp_err, e.err); else pass_cnt++;
      total_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL wr_psel_end: got %b want 0", bus.PSEL); else pass_cnt++;
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      total_cnt++; if (bus.req_ack !== '0) $display("FAIL wr_ack_pulse: got %b want 0", bus.req_ack); else pass_cnt++;
   endtask

   task automatic test_read_wait();
      exp_t e;
      int   pen_cnt = 0;
      int   bad_pwdata = 0;
      int   cyc = 0;
      bit   ok = 1'b0;
      slv_wait = 2;
      set_req(1, 1'b1, 1'b0, 32'h4, 32'h5555);
      sb.push_back('{id: 1, rdata: 32'hABCD, err: 1'b0});
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.PENABLE) pen_cnt++;
         if (bus.PSEL && bus.PWDATA !== '0) bad_pwdata++;
         if (bus.req_ack != '0) begin
            cyc = c;
            ok  = 1'b1;
            break;
         end
      end
      total_cnt++; if (!ok || cyc != 5) $display("FAIL rd_latency: got ok=%b cycles=%0d want 1/5", ok, cyc); else pass_cnt++;
      total_cnt++; if (pen_cnt != 3) $display("FAIL rd_penable_len: got %0d want 3", pen_cnt); else pass_cnt++;
      total_cnt++; if (bad_pwdata != 0) $display("FAIL rd_pwdata_zero: got %0d nonzero cycles want 0", bad_pwdata); else pass_cnt++;
      e = sb.pop_front();
      $display("ack id=%0d ack=%b rdata=%h err=%b", e.id, bus.req_ack, bus.rsp_rdata, bus.rsp_err);
      total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL rd_ack: got %b want onehot %0d", bus.req_ack, e.id); else pass_cnt++;
      total_cnt++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
         $display("FAIL rd_data: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); else pass_cnt++;
      total_cnt++; if (bus.grant_id !== 2'(e.id)) $display("FAIL rd_grant: got %0d want %0d", bus.grant_id, e.id); else pass_cnt++;
      bus.req_valid[1] = 1'b0;
      slv_wait = 0;
      @(negedge clk);
   endtask

   // All four requesters held valid out of reset: grants 0,1,2,3,0, 3 cycles each.
   task automatic test_round_robin();
      exp_t e;
      int   cyc;
      bit   ok;
      rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 32'h40 + 32'(4*i), 32'h100 + 32'(i));
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 5; n++) sb.push_back('{id: n % NUM_REQ, rdata: 32'h0, err: 1'b0});
      for (int n = 0; n < 5; n++) begin
         wait_ack(10, cyc, ok);
         e = sb.pop_front();
         $display("ack id=%0d ack=%b grant=%0d paddr=%h err=%b", e.id, bus.req_ack, bus.grant_id, bus.PADDR, bus.rsp_err);
         total_cnt++; if (!ok || cyc != 3) $display("FAIL rr_period_%0d: got ok=%b cycles=%0d want 1/3", n, ok, cyc); else pass_cnt++;
         total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL rr_ack_%0d: got %b want onehot %0d", n, bus.req_ack, e.id); else pass_cnt++;
         total_cnt++; if (bus.grant_id !== 2'(e.id)) $display("FAIL rr_grant_%0d: got %0d want %0d", n, bus.grant_id, e.id); else pass_cnt++;
         total_cnt++; if (bus.PADDR !== 32'h40 + 32'(4*e.id) || bus.rsp_err !== e.err)
            $display("FAIL rr_cmd_%0d: got a=%h err=%b want %h/%b", n, bus.PADDR, bus.rsp_err, 32'h40 + 32'(4*e.id), e.err); else pass_cnt++;
      end
      bus.req_valid = '0;
      @(negedge clk);
      total_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL rr_idle_after: got psel=%b want 0", bus.PSEL); else pass_cnt++;
   endtask

   task automatic test_timeout();
      exp_t e;
      int   pen_cnt = 0;
      int   cyc = 0;
      bit   ok = 1'b0;
      slv_hang = 1'b1;
      set_req(2, 1'b1, 1'b0, 32'h8, 32'h0);
      sb.push_back('{id: 2, rdata: 32'h0, err: 1'b1});
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (bus.PENABLE) pen_cnt++;
         if (bus.req_ack != '0) begin
            cyc = c;
            ok  = 1'b1;
            break;
         end
      end
      e = sb.pop_front();
      $display("ack id=%0d ack=%b rdata=%h err=%b", e.id, bus.req_ack, bus.rsp_rdata, bus.rsp_err);
      total_cnt++; if (!ok || cyc != TIMEOUT + 2) $display("FAIL to_latency: got ok=%b cycles=%0d want 1/%0d", ok, cyc, TIMEOUT + 2); else pass_cnt++;
      total_cnt++; if (pen_cnt != TIMEOUT) $display("FAIL to_access_len: got %0d want %0d", pen_cnt, TIMEOUT); else pass_cnt++;
      total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL to_ack: got %b want onehot %0d", bus.req_ack, e.id); else pass_cnt++;
      total_cnt++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
         $display("FAIL to_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); else pass_cnt++;
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      total_cnt++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) $display("FAIL to_psel_after: got %b/%b want 0/0", bus.PSEL, bus.PENABLE); else pass_cnt++;
      slv_hang = 1'b0;
   endtask

   // Pointer sits at 2: req3 (error write) wins, then req0 (clean read).
   task automatic test_slave_error();
      exp_t e;
      int   cyc;
      bit   ok;
      err_en = 1'b1;
      set_req(3, 1'b1, 1'b1, 32'hC, 32'h77);
      set_req(0, 1'b1, 1'b0, 32'h4, 32'h0);
      sb.push_back('{id: 3, rdata: 32'h0, err: 1'b1});
      sb.push_back('{id: 0, rdata: 32'hABCD, err: 1'b0});
      for (int n = 0; n < 2; n++) begin
         wait_ack(10, cyc, ok);
         e = sb.pop_front();
         $display("ack id=%0d ack=%b rdata=%h err=%b", e.id, bus.req_ack, bus.rsp_rdata, bus.rsp_err);
         total_cnt++; if (!ok || cyc != 3) $display("FAIL se_period_%0d: got ok=%b cycles=%0d want 1/3", n, ok, cyc); else pass_cnt++;
         total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL se_ack_%0d: got %b want onehot %0d", n, bus.req_ack, e.id); else pass_cnt++;
         total_cnt++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
            $display("FAIL se_rsp_%0d: got %h/%b want %h/%b", n, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); else pass_cnt++;
         bus.req_valid[e.id] = 1'b0;
      end
      err_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   cyc;
      bit   ok;
      int   stray_ack = 0;
      slv_hang = 1'b1;
      set_req(2, 1'b1, 1'b0, 32'h4, 32'h0);
      repeat (2) @(negedge clk);
      total_cnt++; if (bus.PENABLE !== 1'b1 || bus.grant_id !== 2'd2)
         $display("FAIL rm_in_access: got pen=%b grant=%0d want 1/2", bus.PENABLE, bus.grant_id); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.grant_id !== '0 || bus.PADDR !== '0 || bus.req_ack !== '0)
         $display("FAIL rm_async_clear: got psel=%b pen=%b grant=%0d a=%h ack=%b want all 0",
                  bus.PSEL, bus.PENABLE, bus.grant_id, bus.PADDR, bus.req_ack); else pass_cnt++;
      set_req(0, 1'b1, 1'b1, 32'h20, 32'h1234);
      slv_hang = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.req_ack != '0 || bus.PSEL) stray_ack++;
      end
      total_cnt++; if (stray_ack != 0) $display("FAIL rm_no_ack: got %0d active cycles want 0", stray_ack); else pass_cnt++;
      rst = 1'b0;
      sb.push_back('{id: 0, rdata: 32'h0, err: 1'b0});
      sb.push_back('{id: 2, rdata: 32'hABCD, err: 1'b0});
      for (int n = 0; n < 2; n++) begin
         wait_ack(10, cyc, ok);
         e = sb.pop_front();
         $display("ack id=%0d ack=%b rdata=%h err=%b", e.id, bus.req_ack, bus.rsp_rdata, bus.rsp_err);
         total_cnt++; if (!ok || cyc != 3) $display("FAIL rm_period_%0d: got ok=%b cycles=%0d want 1/3", n, ok, cyc); else pass_cnt++;
         total_cnt++; if (bus.req_ack !== (NUM_REQ'(1) << e.id)) $display("FAIL rm_ack_%0d: got %b want onehot %0d", n, bus.req_ack, e.id); else pass_cnt++;
         total_cnt++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
            $display("FAIL rm_rsp_%0d: got %h/%b want %h/%b", n, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); else pass_cnt++;
         bus.req_valid[e.id] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      test_reset();
      test_single_write();
      test_read_wait();
      test_round_robin();
      test_timeout();
      test_slave_error();
      test_reset_mid();

      total_cnt++; if (sb.size() != 0) $display("FAIL sb_drained: got %0d left want 0", sb.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave port, such as the APB_top bus, between NUM_REQ local requesters.
- Arbitrates among pending requests, latches the winner's command, and runs the APB SETUP/ACCESS protocol.
- Returns read data and error status to the winning requester with a one-cycle acknowledge pulse.
- Adds a wait-state timeout so a slave that never asserts PREADY cannot hang the bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced termination (>=2)

Ports:
PCLK  input  1  clock, rising edge
PRESET  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request; held with its fields until req_ack
req_write  input  NUM_REQ  per-requester direction, 1=write
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  flattened write data, same packing as req_addr
req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  output  DATA_W  read data, valid while req_ack is high
rsp_err  output  1  error flag (PSLVERR or timeout), valid while req_ack is high
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDR_W  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_W  APB write data
PREADY  input  1  APB slave ready
PRDATA  input  DATA_W  APB read data
PSLVERR  input  1  APB slave error

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is asynchronous and active-high.
- All outputs are registered.
- Reset values: state IDLE, all outputs 0, RR pointer = NUM_REQ-1 (requester 0 has first priority).
- FSM state IDLE:
  - Eligible requests = req_valid & ~req_ack. The requester being acked this cycle is masked.
  - If any request is eligible, pick the first eligible index scanning from pointer+1, wrapping modulo NUM_REQ.
  - Latch the winner's addr, write and wdata into PADDR/PWRITE/PWDATA. For a read, PWDATA = 0.
  - Set grant_id = winner, pointer = winner, PSEL = 1, then go to SETUP.
- FSM state SETUP (PSEL=1, PENABLE=0, exactly one cycle): set PENABLE = 1, clear the wait counter, go to ACCESS.
- FSM state ACCESS (PSEL=1, PENABLE=1):
  - On an edge with PREADY=1: PSEL and PENABLE go to 0; req_ack[grant_id] = 1 for one cycle.
  - On that same edge: rsp_rdata = PRDATA for reads, 0 for writes; rsp_err = PSLVERR; go to IDLE.
  - On an edge with PREADY=0: the wait counter increments.
  - Timeout: when the counter reaches TIMEOUT-1 with PREADY still 0, terminate. PSEL and PENABLE go to 0, ack is pulsed, rsp_err = 1, rsp_rdata = 0, go to IDLE.
- Latency:
  - PSEL rises 1 cycle after the edge on which IDLE samples a request.
  - Zero-wait transfer: 3 cycles from request sample to ack.
  - Back-to-back transfers occupy IDLE, SETUP, ACCESS, i.e. 3 cycles each minimum.
- Output stability:
  - PADDR, PWRITE, PWDATA stay stable from SETUP through the end of ACCESS.
  - Outside a transfer they hold their last values.
  - grant_id holds until the next grant.
- rsp_rdata and rsp_err hold their values after the ack pulse. They are defined only during the ack cycle.
- Simultaneous requests: only one is granted per transfer. Losers keep waiting.
- A requester re-asserting req_valid in the cycle after its ack is eligible, at the lowest RR priority.
- req_valid dropping mid-transfer is ignored: the transfer completes on the latched command and the ack is still issued.
- PRESET mid-transfer: immediate return to reset values. No ack is issued and the transfer is abandoned.
- PREADY and PSLVERR are ignored outside ACCESS.

Test Plan:
- Single write: req0 write, addr 0x4, data 0xABCD.
  - Expect SETUP then ACCESS with PADDR=0x4, PWRITE=1, PWDATA=0xABCD.
  - With PREADY=1 immediately: req_ack=0001 exactly 3 cycles after the sample, rsp_err=0.
- Read back with 2 wait states: req1 read of 0x4, slave returns PRDATA=0xABCD.
  - Expect PENABLE high for 3 cycles.
  - Expect req_ack=0010 with rsp_rdata=0xABCD and PWDATA=0 during the transfer.
- Round robin: req0..req3 all held valid from reset.
  - Grant order 0,1,2,3,0.
  - No requester is granted twice while another is pending.
  - Every transfer is exactly 3 cycles when PREADY is tied to 1.
- Timeout: TIMEOUT=16, PREADY held at 0.
  - ACCESS lasts 16 cycles, then ack with rsp_err=1 and rsp_rdata=0.
  - PSEL=0 on the following cycle.
- Slave error: write with PSLVERR=1 at PREADY.
  - ack with rsp_err=1.
  - The next requester is granted normally.
- Reset mid-op: assert PRESET during ACCESS of req2.
  - All outputs are 0 asynchronously and no ack is issued.
  - After deassert, req0 is granted first when req0 and req2 are both valid.
